// File: rtl/glitch_filter.sv
// Stability filter and edge detector for an already-synchronized level.
// data_out follows data_in only after STABLE_CYCLES consecutive differing samples.
module glitch_filter #(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    output logic data_out,
    output logic rising_edge,
    output logic falling_edge,
    output logic pending
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_param_check
        $error("glitch_filter: STABLE_CYCLES must be >= 1 (got %0d)", STABLE_CYCLES);
    end

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             data_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             pending_nxt;

    // Qualification: count differing samples, commit the change on the last one.
    always_comb begin
        count_nxt = '0;
        data_nxt  = data_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (data_in != data_out) begin
            if (count == CNT_MAX) begin
                data_nxt = data_in;
                rise_nxt = data_in;
                fall_nxt = ~data_in;
            end else begin
                count_nxt = count + CNT_W'(1);
            end
        end
        pending_nxt = (count_nxt != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            data_out     <= RESET_VALUE;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            pending      <= 1'b0;
        end else begin
            count        <= count_nxt;
            data_out     <= data_nxt;
            rising_edge  <= rise_nxt;
            falling_edge <= fall_nxt;
            pending      <= pending_nxt;
        end
    end

endmodule
